// File: rtl/mash_serial_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mash_serial_rx_pkg
//  Description : Shared definitions for the MASH serial link receiver.
//                Holds the receiver FSM state encoding, the default frame
//                width and a width helper for sizing counters.
//                Build option MASH_RX_ERRCNT_EN (used by mash_serial_rx)
//                enables the saturating truncated-frame counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mash_serial_rx_pkg;

    // Frame width used by the truncator output word.
    localparam int DEF_FRAME_BITS = 3;

    // Receiver FSM states.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

    // Bits needed to hold the values 0 .. value-1 (never less than 1).
    function automatic int cnt_width(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mash_bit_sync.sv
`default_nettype none
// ============================================================================
//  Module      : mash_bit_sync
//  Description : Single-bit multi-flop synchroniser into the clck domain.
//                Both serial lines use an identical instance so that data
//                stays aligned with its toggle.
//  Ports       : clck   - local clock
//                rst    - asynchronous active-high reset, clears the chain
//                d_i    - asynchronous input bit
//                q_o    - synchronised bit, STAGES clck cycles later
//  Revision    : 1.0 - initial release
// ============================================================================
module mash_bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clck,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/mash_serial_rx.sv
`default_nettype none
// ============================================================================
//  Module      : mash_serial_rx
//  Description : Receiver for the MASH truncator serial link. Each edge of
//                sclk_in (rising or falling) carries one data bit on sig_in,
//                LSB first. Both lines are synchronised into clck, toggles
//                are detected, FRAME_BITS-bit words are assembled and
//                presented with a one-cycle word_valid pulse. A frame that
//                stalls for TIMEOUT clck cycles is dropped with a one-cycle
//                frame_err pulse.
//  Ports       : clck       - system clock
//                rst        - asynchronous active-high reset
//                sig_in     - serial data
//                sclk_in    - serial toggle clock
//                word_out   - recovered word (two's complement), held
//                word_valid - one-cycle pulse, word_out updated
//                frame_err  - one-cycle pulse, frame dropped on timeout
//                err_cnt    - saturating truncated-frame count
//  Options     : MASH_RX_ERRCNT_EN - when defined, err_cnt counts frame_err
//                pulses and saturates at 255; otherwise err_cnt is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mash_serial_rx
    import mash_serial_rx_pkg::*;
#(
    parameter int FRAME_BITS  = DEF_FRAME_BITS,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                  clck,
    input  logic                  rst,
    input  logic                  sig_in,
    input  logic                  sclk_in,
    output logic [FRAME_BITS-1:0] word_out,
    output logic                  word_valid,
    output logic                  frame_err,
    output logic [7:0]            err_cnt
);

    localparam int CW = cnt_width(FRAME_BITS);
    localparam int TW = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] C_LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic w_sig_s;
    logic w_sclk_s;

    mash_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_sig (
        .clck (clck),
        .rst  (rst),
        .d_i  (sig_in),
        .q_o  (w_sig_s)
    );

    mash_bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync_sclk (
        .clck (clck),
        .rst  (rst),
        .d_i  (sclk_in),
        .q_o  (w_sclk_s)
    );

    // ------------------------------------------------------------------
    // Toggle detection: either edge of the synchronised clock is a bit
    // ------------------------------------------------------------------
    logic sclk_prev_q;
    logic w_toggle;

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_prev_q <= w_sclk_s;
        end
    end

    assign w_toggle = w_sclk_s ^ sclk_prev_q;

    // ------------------------------------------------------------------
    // Timeout counter: cleared by every toggle, saturates at TIMEOUT-1
    // ------------------------------------------------------------------
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (w_toggle) begin
            tmo_d = '0;
        end else if (tmo_q != C_TMO_LAST) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame assembly FSM
    // ------------------------------------------------------------------
    rx_state_e             state_q;
    logic [CW-1:0]         bit_cnt_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [FRAME_BITS-1:0] word_q;
    logic                  valid_q;
    logic                  ferr_q;
    logic [FRAME_BITS-1:0] w_asm;
    logic                  w_expire;

    // Shift register with the incoming bit merged at the current position,
    // so a completing frame can be captured into word_q in the same cycle.
    always_comb begin
        w_asm = shreg_q;
        for (int i = 0; i < FRAME_BITS; i++) begin
            if (bit_cnt_q == CW'(i)) begin
                w_asm[i] = w_sig_s;
            end
        end
    end

    // A toggle on the expiry cycle takes priority and keeps the frame alive.
    assign w_expire = (state_q == ST_RECV) && !w_toggle && (tmo_q == C_TMO_LAST);

    // In IDLE bit_cnt_q is always 0, so the first toggle follows the same
    // store-and-advance path as every later bit of the frame.
    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (w_toggle) begin
                if (bit_cnt_q == C_LAST_BIT) begin
                    word_q    <= w_asm;
                    valid_q   <= 1'b1;
                    shreg_q   <= '0;
                    bit_cnt_q <= '0;
                    state_q   <= ST_IDLE;
                end else begin
                    shreg_q   <= w_asm;
                    bit_cnt_q <= bit_cnt_q + CW'(1);
                    state_q   <= ST_RECV;
                end
            end else if (w_expire) begin
                shreg_q   <= '0;
                bit_cnt_q <= '0;
                ferr_q    <= 1'b1;
                state_q   <= ST_IDLE;
            end
        end
    end

    assign word_out   = word_q;
    assign word_valid = valid_q;
    assign frame_err  = ferr_q;

    // ------------------------------------------------------------------
    // Truncated-frame counter
    // ------------------------------------------------------------------
`ifdef MASH_RX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clck or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else if (w_expire && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
`default_nettype wire
